// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder: multi-cycle add/sub, CHUNK bits per clock with valid/ready handshakes.
// Define PIPELINED_CHUNK_ADDER_SAT_EN to saturate Sum on signed overflow.
module pipelined_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("pipelined_chunk_adder: illegal WIDTH/CHUNK combination");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, bx_r, res, res_n, sum_ld;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             carry, c_out, c_msb, ovf_n, last;
  logic [CW-1:0]    cnt;
  assign in_ready = state == IDLE;
  always_comb begin
    a_ch = a_r[cnt*CHUNK +: CHUNK];
    b_ch = bx_r[cnt*CHUNK +: CHUNK];
    {c_out, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
    // carry into the top bit of the chunk, recovered from its sum bit
    c_msb = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
    ovf_n = c_msb ^ c_out;
    res_n = res;
    res_n[cnt*CHUNK +: CHUNK] = s_ch;
    last = cnt == CW'(NCHUNK - 1);
    state_n = state == IDLE ? (in_valid ? CALC : IDLE) :
              state == CALC ? (last ? DONE : CALC) :
              (out_ready ? IDLE : DONE);
  end
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
  assign sum_ld = ovf_n ? {a_r[WIDTH-1], {(WIDTH-1){~a_r[WIDTH-1]}}} : res_n;
`else
  assign sum_ld = res_n;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      bx_r      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a_r   <= A;
        bx_r  <= Sub ? ~B : B;
        carry <= Sub ^ Cin;
        cnt   <= '0;
      end
      if (state == CALC) begin
        res   <= res_n;
        carry <= c_out;
        cnt   <= cnt + CW'(1);
      end
      if (state == CALC && last) begin
        Sum       <= sum_ld;
        Cout      <= c_out;
        Ovf       <= ovf_n;
        out_valid <= 1'b1;
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// tb_pipelined_chunk_adder: three instances (CHUNK=4,16,1) checked against a behavioural model.
module tb_pipelined_chunk_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        Cin = 1'b0, Sub = 1'b0;
  logic        iv [3], ir [3], ov [3], ordy [3], co [3], of [3];
  logic [15:0] sm [3];
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipelined_chunk_adder #(.WIDTH(16), .CHUNK(g == 0 ? 4 : g == 1 ? 16 : 1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
      .A(A), .B(B), .Cin(Cin), .Sub(Sub),
      .out_valid(ov[g]), .out_ready(ordy[g]),
      .Sum(sm[g]), .Cout(co[g]), .Ovf(of[g])
    );
  end

  function automatic int nch(int k);
    return k == 0 ? 4 : k == 1 ? 1 : 16;
  endfunction

  // returns {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [17:0] gold(input logic [15:0] a, b, input logic cin, sub);
    int r, ua, ub, uc;
    logic [16:0] u;
    logic [15:0] s;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    uc = int'(cin);
    if (sub) begin
      r = int'($signed(a)) - int'($signed(b)) - uc;
      c = ua >= ub + uc;
      s = 16'(ua - ub - uc);
    end else begin
      r = int'($signed(a)) + int'($signed(b)) + uc;
      u = 17'(ua + ub + uc);
      c = u[16];
      s = u[15:0];
    end
    o = r > 32767 || r < -32768;
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
    if (o) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {o, c, s};
  endfunction

  logic        busy [3] = '{default: 1'b0};
  logic        mv [3] = '{default: 1'b0};
  logic        mc [3] = '{default: 1'b0};
  logic        mo [3] = '{default: 1'b0};
  logic [15:0] ms [3] = '{default: 16'h0};
  logic [17:0] pend [3] = '{default: 18'h0};
  int          rem [3] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        busy[k] = 1'b0; mv[k] = 1'b0; mc[k] = 1'b0; mo[k] = 1'b0; ms[k] = '0; rem[k] = 0;
      end else if (!busy[k]) begin
        if (iv[k]) begin
          busy[k] = 1'b1;
          rem[k] = nch(k);
          pend[k] = gold(A, B, Cin, Sub);
        end
      end else if (rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) {mv[k], mo[k], mc[k], ms[k]} = {1'b1, pend[k]};
      end else if (ordy[k]) begin
        mv[k] = 1'b0;
        busy[k] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("in_ready", k, 32'(ir[k]), 32'(!busy[k]));
      chk("out_valid", k, 32'(ov[k]), 32'(mv[k]));
      chk("sum", k, 32'(sm[k]), 32'(ms[k]));
      chk("cout", k, 32'(co[k]), 32'(mc[k]));
      chk("ovf", k, 32'(of[k]), 32'(mo[k]));
    end
  end

  task automatic drain();
    for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
    for (int i = 0; i < 60 && (busy[0] || busy[1] || busy[2]); i++) @(negedge clk);
    chk("idle_wait", 0, 32'(busy[0] | busy[1] | busy[2]), 32'(0));
    for (int k = 0; k < 3; k++) ordy[k] = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, b, input logic cin, sub,
                        input logic [15:0] es, input logic ec, eo);
    int   lat [3];
    logic seen [3];
    drain();
    A = a; B = b; Cin = cin; Sub = sub;
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b1; seen[k] = 1'b0; lat[k] = 0; end
    @(negedge clk);
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    for (int n = 1; n <= 40 && !(seen[0] && seen[1] && seen[2]); n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (ov[k] && !seen[k]) begin seen[k] = 1'b1; lat[k] = n; end
    end
    for (int k = 0; k < 3; k++) begin
      chk("latency", k, 32'(lat[k]), 32'(nch(k)));
      chk("lit_sum", k, 32'(sm[k]), 32'(es));
      chk("lit_cout", k, 32'(co[k]), 32'(ec));
      chk("lit_ovf", k, 32'(of[k]), 32'(eo));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; ordy[k] = 1'b0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", 0, 32'(ir[0]), 32'(1));
    chk("idle_valid", 0, 32'(ov[0]), 32'(0));
    chk("idle_sum", 0, 32'(sm[0]), 32'(0));
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    // backpressure: new operands offered while the result is held
    A = 16'h1234; B = 16'h1111; Cin = 1'b0; Sub = 1'b0;
    for (int k = 0; k < 3; k++) iv[k] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 0, 32'(ir[0]), 32'(0));
      chk("bp_valid", 0, 32'(ov[0]), 32'(1));
      chk("bp_sum", 0, 32'(sm[0]), 32'(16'h0001));
    end
    for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 0, 32'(ir[0]), 32'(1));
    chk("bp_release_valid", 0, 32'(ov[0]), 32'(0));
    for (int k = 0; k < 3; k++) ordy[k] = 1'b0;
    @(negedge clk);
    chk("bp_accept", 0, 32'(ir[0]), 32'(0));
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    repeat (20) @(negedge clk);
    chk("bp_new_sum", 0, 32'(sm[0]), 32'(16'h2345));
    // reset during the second CALC cycle
    drain();
    A = 16'hABCD; B = 16'h0F0F; Cin = 1'b1; Sub = 1'b1;
    for (int k = 0; k < 3; k++) iv[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 0, 32'(ir[0]), 32'(1));
    chk("rst_valid", 0, 32'(ov[0]), 32'(0));
    chk("rst_sum", 0, 32'(sm[0]), 32'(0));
    chk("rst_cout", 0, 32'(co[0]), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rst_no_valid", 0, 32'(ov[0]), 32'(0));
    end
    // random traffic on all three instances
    repeat (3000) begin
      @(negedge clk);
      A = 16'($urandom); B = 16'($urandom);
      Cin = 1'($urandom); Sub = 1'($urandom);
      for (int k = 0; k < 3; k++) begin
        iv[k] = 1'($urandom);
        ordy[k] = ($urandom % 4) != 0;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_chunk_adder.md
Name: pipelined_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, carrying between cycles in a register.
- Uses valid/ready handshakes on input and output so it drops into streaming datapaths.
- Trades latency for a short carry chain: the critical path is CHUNK full-adder stages, not WIDTH.

Parameters:
- WIDTH, 16, operand and result width in bits; WIDTH >= 2.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0 (elaboration error otherwise).
- NCHUNK, WIDTH/CHUNK, derived (localparam): number of compute cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/mode present
- in_ready  out  1  block can accept operands
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Cin  in  1  carry-in (add) / borrow-in (sub)
- Sub  in  1  0: A+B+Cin; 1: A-B-Cin
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- Sum  out  WIDTH  result
- Cout  out  1  carry-out; in sub mode 1 = no borrow, 0 = borrow
- Ovf  out  1  two's-complement overflow

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0, Ovf=0, internal registers cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch A and Bx = Sub ? ~B : B into operand registers.
  - Latch carry = Sub ? ~Cin : Cin. Set chunk counter=0 and go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, add chunk cnt of A and Bx plus the carry register (CHUNK-bit ripple), write the result chunk into an internal result register, and update carry.
  - At the MSB chunk, also capture carry into bit WIDTH-1 for Ovf.
  - After chunk NCHUNK-1, copy result, carry and Ovf (= carry into MSB XOR carry out of MSB) to Sum/Cout/Ovf, set out_valid=1 and go to DONE.
- DONE:
  - in_ready=0, out_valid=1.
  - Sum/Cout/Ovf stable until out_ready.
  - On out_ready, deassert out_valid and go to IDLE.
- Latency: out_valid rises on the NCHUNK-th rising edge after the accepting edge. With CHUNK==WIDTH the latency is 1 cycle.
- Throughput: one operation per NCHUNK+2 cycles minimum (accept, NCHUNK compute, drain). There is no overlap of operations.
- in_valid while in_ready=0 is ignored; operands are not latched and no error is raised.
- Sum/Cout/Ovf hold the previous result between operations and change only on the CALC->DONE transition. They are meaningful only when out_valid=1.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Cout is bit WIDTH of the extended sum.
  - No sign-extension of inputs.
- Reset mid-CALC or mid-DONE: immediate return to reset values; the in-flight operation is discarded.

Optional Feature:
- Macro: PIPELINED_CHUNK_ADDER_SAT_EN.
- Defined:
  - On Ovf=1 the loaded Sum saturates: 2^(WIDTH-1)-1 if operand A's MSB=0, else 2^(WIDTH-1).
  - Ovf and Cout are reported unchanged.
  - Latency is unchanged (saturation is muxed into the DONE load).
- Undefined: Sum is the wrapped result; no saturation logic is present.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Reset:
  - Assert rst_n=0 asynchronously mid-cycle -> in_ready=1, out_valid=0, Sum=0x0000, Cout=0, Ovf=0 immediately.
  - Release, then apply no stimulus -> outputs unchanged.
- Carry across all chunks:
  - A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> Sum=0x0000, Cout=1, Ovf=0.
  - out_valid is high exactly 4 edges after the accept edge.
- Signed overflow:
  - A=0x7FFF, B=0x0001, Sub=0 -> Cout=0, Ovf=1.
  - Without the macro, Sum=0x8000.
  - With PIPELINED_CHUNK_ADDER_SAT_EN, Sum=0x7FFF.
- Subtract with borrow:
  - A=0x0005, B=0x0007, Cin=0, Sub=1 -> Sum=0xFFFE, Cout=0, Ovf=0.
  - A=0x0005, B=0x0003, Cin=1, Sub=1 -> Sum=0x0001, Cout=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands -> Sum/Cout/Ovf and out_valid stable, in_ready=0.
  - The new operands are not taken until the cycle after out_ready=1 returns the block to IDLE.
- Reset mid-operation and parameter corners:
  - Assert rst_n on the 2nd CALC cycle -> out_valid never rises, state IDLE, outputs 0.
  - Re-run with CHUNK=16 -> 1-cycle latency.
  - Re-run with CHUNK=1 -> 16-cycle latency.
  - Both give identical results for random vectors against a behavioural golden model.
